// File: rtl/btn_sw_pkg.sv
// Shared constants and state encoding for the button/switch input conditioner.
package btn_sw_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int LONG_CYCLES_DEFAULT     = 100000000;
  localparam int DEBOUNCE_CYCLES_SIM     = 8;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One conditioned input: 2-flop synchroniser, debounce FSM/counter, registered edge pulses.
module debounce_chan
  import btn_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output deb_state_e state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1, sync2;
  deb_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_nx, rise_nx, fall_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // The count holds how many consecutive cycles sync2 has disagreed with level.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      ST_STABLE: begin
        cnt_nx = '0;
        if (sync2 != level) begin
          state_nx = ST_SETTLING;
          cnt_nx   = CNT_ONE;
        end
      end
      ST_SETTLING: begin
        if (sync2 == level) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
          level_nx = sync2;
          rise_nx  = sync2;
          fall_nx  = ~sync2;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: rtl/btn_sw_conditioner.sv
// Conditions raw BTN/SW pins into debounced levels and single-cycle edge pulses.
// Define BTN_LONG_PRESS_EN to add per-button long-press pulses on o_btn_long.
module btn_sw_conditioner
  import btn_sw_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic             i_CLK100MHZ,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [N_SW-1:0]  i_sw,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic [N_BTN-1:0] o_btn_long,
  output logic [N_SW-1:0]  o_sw_level,
  output logic [N_SW-1:0]  o_sw_change
);

  localparam int N_CH = N_BTN + N_SW;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must lie in 2 .. 2^24-1");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end

  // Buttons occupy the low channels, switches the high ones.
  logic [N_CH-1:0] chan_pin;
  logic [N_CH-1:0] chan_level;
  logic [N_CH-1:0] chan_rise;
  logic [N_CH-1:0] chan_fall;
  logic [N_CH-1:0] chan_state_unused;

  assign chan_pin = {i_sw, i_btn};

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (i_CLK100MHZ),
      .rst      (i_rst),
      .pin      (chan_pin[i]),
      .level    (chan_level[i]),
      .rise     (chan_rise[i]),
      .fall     (chan_fall[i]),
      .state_dbg(chan_state_unused[i])
    );
  end

  assign o_btn_level   = chan_level[N_BTN-1:0];
  assign o_btn_press   = chan_rise[N_BTN-1:0];
  assign o_btn_release = chan_fall[N_BTN-1:0];
  assign o_sw_level    = chan_level[N_CH-1:N_BTN];
  assign o_sw_change   = chan_rise[N_CH-1:N_BTN] | chan_fall[N_CH-1:N_BTN];

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0]    hold_cnt [N_BTN];
  logic [N_BTN-1:0] long_fired;
  logic [N_BTN-1:0] long_q;

  // Counter parks at LONG_CYCLES-1; long_fired blocks repeats until release.
  always_ff @(posedge i_CLK100MHZ) begin
    if (i_rst) begin
      for (int b = 0; b < N_BTN; b++) hold_cnt[b] <= '0;
      long_fired <= '0;
      long_q     <= '0;
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        if (!o_btn_level[b]) begin
          hold_cnt[b]   <= '0;
          long_fired[b] <= 1'b0;
          long_q[b]     <= 1'b0;
        end else begin
          if (hold_cnt[b] != HOLD_LAST) hold_cnt[b] <= hold_cnt[b] + 1'b1;
          long_q[b] <= (hold_cnt[b] == HOLD_LAST) && !long_fired[b];
          if (hold_cnt[b] == HOLD_LAST) long_fired[b] <= 1'b1;
        end
      end
    end
  end

  assign o_btn_long = long_q;
`else
  assign o_btn_long = '0;
`endif

endmodule
